// File: rtl/rv32_csr_pkg.sv
// Shared constants for the RV32 machine-mode CSR block: addresses, op encodings,
// interrupt causes, bit positions and WARL masks.
package rv32_csr_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [11:0] CSR_SSTATUS   = 12'h180;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MEDELEG   = 12'h302;
    localparam logic [11:0] CSR_MIDELEG   = 12'h303;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_PMPCFG0   = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0  = 12'h3B0;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_TIME      = 12'hC01;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_TIMEH     = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // csr_op[1:0] selects the operation, csr_op[2] selects the immediate form
    localparam logic [1:0] OPK_RW = 2'b01;
    localparam logic [1:0] OPK_RS = 2'b10;
    localparam logic [1:0] OPK_RC = 2'b11;

    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIE_MSIE_BIT     = 3;
    localparam int unsigned MIE_MTIE_BIT     = 7;
    localparam int unsigned MIE_MEIE_BIT     = 11;

    localparam logic [31:0] MIE_WARL_MASK  = 32'h0000_0888;
    localparam logic [31:0] MEPC_WARL_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/rv32_csr_counter.sv
// Free-running counter with split 32-bit lo/hi write port; WIDTH of 32 keeps the
// high half at zero.
module rv32_csr_counter
    import rv32_csr_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_en_i,
    input  logic            wr_lo_i,
    input  logic            wr_hi_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] lo_o,
    output logic [XLEN-1:0] hi_o
);

    localparam logic [63:0] CNT_MASK = (WIDTH == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                     : 64'h0000_0000_FFFF_FFFF;

    logic [63:0] cnt_q, cnt_d;

    // A write to either half suppresses the increment of the whole counter
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0]  = wdata_i;
            if (wr_hi_i) cnt_d[63:32] = wdata_i;
        end else if (inc_en_i) begin
            cnt_d = cnt_q + 64'd1;
        end
        cnt_d = cnt_d & CNT_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign lo_o = cnt_q[31:0];
    assign hi_o = cnt_q[63:32];

endmodule

// File: rtl/rv32_csr_unit.sv
// Machine-mode CSR block for the RV32I core: CSR read/write port, internal
// counters, trap entry / MRET sequencing and interrupt arbitration.
module rv32_csr_unit
    import rv32_csr_pkg::*;
#(
    parameter int unsigned HART_ID           = 0,
    parameter logic [31:0] MISA_VALUE        = 32'h4000_0100,
    parameter int unsigned CNT_WIDTH         = 64,
    parameter bit          MTVEC_VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [2:0]  csr_op,
    input  logic        csr_we,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        instret_inc,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_tval,
    input  logic        mret_req,
    input  logic        irq_msi,
    input  logic        irq_mti,
    input  logic        irq_mei,
    output logic        irq_take,
    output logic [31:0] irq_cause,
    output logic [31:0] trap_target,
    output logic [31:0] mepc_out
);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic        irq_take_q, irq_take_d;
    logic [31:0] irq_cause_q, irq_cause_d;

    logic [31:0] cycle_lo, cycle_hi, instret_lo, instret_hi;
    logic [31:0] mstatus_val, mip_val, wsrc, wval, base;
    logic        wr_en;

    assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
    assign mip_val     = {20'b0, irq_mei, 3'b0, irq_mti, 3'b0, irq_msi, 3'b0};

    // Combinational read of the pre-write value and address decode
    always_comb begin
        csr_rdata   = '0;
        csr_illegal = 1'b0;
        case (csr_addr)
            CSR_MSTATUS:  csr_rdata = mstatus_val;
            CSR_MISA:     csr_rdata = MISA_VALUE;
            CSR_MIE:      csr_rdata = mie_q;
            CSR_MTVEC:    csr_rdata = mtvec_q;
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            CSR_MEPC:     csr_rdata = mepc_q;
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_MTVAL:    csr_rdata = mtval_q;
            CSR_MIP:      csr_rdata = mip_val;
            CSR_MCYCLE, CSR_CYCLE, CSR_TIME:        csr_rdata = cycle_lo;
            CSR_MCYCLEH, CSR_CYCLEH, CSR_TIMEH:     csr_rdata = cycle_hi;
            CSR_MINSTRET, CSR_INSTRET:              csr_rdata = instret_lo;
            CSR_MINSTRETH, CSR_INSTRETH:            csr_rdata = instret_hi;
            CSR_MHARTID:  csr_rdata = 32'(HART_ID);
            CSR_SSTATUS, CSR_MEDELEG, CSR_MIDELEG, CSR_PMPCFG0, CSR_PMPADDR0,
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_rdata = '0;
            default:      csr_illegal = 1'b1;
        endcase
        if (csr_we && csr_addr[11:10] == 2'b11) csr_illegal = 1'b1;
    end

    always_comb begin
        wsrc = csr_op[2] ? {27'b0, csr_wdata[4:0]} : csr_wdata;
        case (csr_op[1:0])
            OPK_RW:  wval = wsrc;
            OPK_RS:  wval = csr_rdata | wsrc;
            OPK_RC:  wval = csr_rdata & ~wsrc;
            default: wval = csr_rdata;
        endcase
        wr_en = csr_we && (csr_op[1:0] != 2'b00) && !csr_illegal && !trap_req && !mret_req;
    end

    // Trap beats MRET beats CSR write
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (trap_req) begin
            mepc_d         = trap_epc & MEPC_WARL_MASK;
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_req) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wval[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = wval[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d      = wval & MIE_WARL_MASK;
                CSR_MTVEC:    mtvec_d    = {wval[31:2],
                                            (MTVEC_VECTORED_EN && wval[1:0] == 2'b01) ? 2'b01 : 2'b00};
                CSR_MSCRATCH: mscratch_d = wval;
                CSR_MEPC:     mepc_d     = wval & MEPC_WARL_MASK;
                CSR_MCAUSE:   mcause_d   = wval;
                CSR_MTVAL:    mtval_d    = wval;
                default: ;
            endcase
        end
    end

    // Interrupt arbitration on registered enables: MEI > MSI > MTI
    always_comb begin
        irq_take_d  = 1'b0;
        irq_cause_d = '0;
        if (mstatus_mie_q) begin
            if (irq_mei && mie_q[MIE_MEIE_BIT]) begin
                irq_take_d  = 1'b1;
                irq_cause_d = CAUSE_MEI;
            end else if (irq_msi && mie_q[MIE_MSIE_BIT]) begin
                irq_take_d  = 1'b1;
                irq_cause_d = CAUSE_MSI;
            end else if (irq_mti && mie_q[MIE_MTIE_BIT]) begin
                irq_take_d  = 1'b1;
                irq_cause_d = CAUSE_MTI;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            irq_take_q     <= 1'b0;
            irq_cause_q    <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            irq_take_q     <= irq_take_d;
            irq_cause_q    <= irq_cause_d;
        end
    end

    rv32_csr_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
        .clk      (clk),
        .rst      (rst),
        .inc_en_i (1'b1),
        .wr_lo_i  (wr_en && csr_addr == CSR_MCYCLE),
        .wr_hi_i  (wr_en && csr_addr == CSR_MCYCLEH),
        .wdata_i  (wval),
        .lo_o     (cycle_lo),
        .hi_o     (cycle_hi)
    );

    rv32_csr_counter #(.WIDTH(CNT_WIDTH)) u_instret (
        .clk      (clk),
        .rst      (rst),
        .inc_en_i (instret_inc),
        .wr_lo_i  (wr_en && csr_addr == CSR_MINSTRET),
        .wr_hi_i  (wr_en && csr_addr == CSR_MINSTRETH),
        .wdata_i  (wval),
        .lo_o     (instret_lo),
        .hi_o     (instret_hi)
    );

    always_comb begin
        base = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && trap_cause[31])
            trap_target = base + {25'b0, trap_cause[4:0], 2'b00};
        else
            trap_target = base;
    end

    assign irq_take  = irq_take_q;
    assign irq_cause = irq_cause_q;
    assign mepc_out  = mepc_q;

endmodule

// File: tb/tb_rv32_csr_unit.sv
// Directed self-checking bench for rv32_csr_unit with hand-computed expectations.
module tb_rv32_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [2:0]  csr_op;
    logic        csr_we;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instret_inc;
    logic        trap_req;
    logic [31:0] trap_cause, trap_epc, trap_tval;
    logic        mret_req;
    logic        irq_msi, irq_mti, irq_mei;
    logic        irq_take;
    logic [31:0] irq_cause, trap_target, mepc_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32_csr_unit #(
        .HART_ID           (5),
        .MISA_VALUE        (32'h4000_0100),
        .CNT_WIDTH         (64),
        .MTVEC_VECTORED_EN (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_op      (csr_op),
        .csr_we      (csr_we),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .instret_inc (instret_inc),
        .trap_req    (trap_req),
        .trap_cause  (trap_cause),
        .trap_epc    (trap_epc),
        .trap_tval   (trap_tval),
        .mret_req    (mret_req),
        .irq_msi     (irq_msi),
        .irq_mti     (irq_mti),
        .irq_mei     (irq_mei),
        .irq_take    (irq_take),
        .irq_cause   (irq_cause),
        .trap_target (trap_target),
        .mepc_out    (mepc_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
        csr_addr  = a;
        csr_op    = op;
        csr_wdata = d;
        csr_we    = 1'b1;
        tick();
        csr_we    = 1'b0;
        csr_op    = 3'b000;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        csr_we   = 1'b0;
        csr_op   = 3'b000;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    initial begin
        rst = 1'b1; csr_addr = '0; csr_wdata = '0; csr_op = '0; csr_we = 1'b0;
        instret_inc = 1'b0; trap_req = 1'b0; trap_cause = '0; trap_epc = '0;
        trap_tval = '0; mret_req = 1'b0; irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_irq_take", 32'(irq_take), 32'd0);
        check("rst_irq_cause", irq_cause, 32'd0);
        check("rst_mepc_out", mepc_out, 32'd0);
        rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);
        check("mstatus_legal", 32'(csr_illegal), 32'd0);
        rd_chk("rst_misa", 12'h301, 32'h4000_0100);
        rd_chk("rst_mhartid", 12'hF14, 32'd5);
        rd_chk("unlisted_rd", 12'h7C0, 32'd0);
        check("unlisted_illegal", 32'(csr_illegal), 32'd1);
        tick();
        rd_chk("rst_mtvec", 12'h305, 32'd0);

        // mstatus WARL and immediate clear
        csr_wr(12'h300, 3'b001, 32'hFFFF_FFFF);
        rd_chk("mstatus_rw_all", 12'h300, 32'h0000_1888);
        csr_wr(12'h300, 3'b111, 32'd8);
        rd_chk("mstatus_rci", 12'h300, 32'h0000_1880);
        csr_wr(12'h340, 3'b100, 32'h55);
        rd_chk("bad_op_nowrite", 12'h340, 32'd0);
        csr_wr(12'h305, 3'b001, 32'h0000_0103);
        rd_chk("mtvec_mode3", 12'h305, 32'h0000_0100);

        // Cycle counter carry from lo into hi
        csr_wr(12'hB00, 3'b001, 32'hFFFF_FFFE);
        csr_wr(12'hB80, 3'b001, 32'd0);
        repeat (3) tick();
        rd_chk("mcycle_lo", 12'hB00, 32'd1);
        rd_chk("mcycle_hi", 12'hB80, 32'd1);
        csr_addr = 12'hC00; csr_op = 3'b001; csr_wdata = 32'h1234; csr_we = 1'b1;
        #1;
        check("cycle_ro_illegal", 32'(csr_illegal), 32'd1);
        tick();
        csr_we = 1'b0; csr_op = 3'b000;
        rd_chk("cycle_alias_lo", 12'hC00, 32'd2);
        rd_chk("cycle_alias_hi", 12'hC80, 32'd1);

        // Retired-instruction counter
        instret_inc = 1'b1;
        repeat (3) tick();
        instret_inc = 1'b0;
        rd_chk("minstret", 12'hB02, 32'd3);
        rd_chk("instret_alias", 12'hC02, 32'd3);
        rd_chk("minstreth", 12'hB82, 32'd0);

        // Timer interrupt, trap entry into vectored mtvec
        csr_wr(12'h305, 3'b001, 32'h0000_0101);
        csr_wr(12'h304, 3'b001, 32'h0000_0080);
        csr_wr(12'h300, 3'b110, 32'd8);
        irq_mti = 1'b1;
        #1;
        check("irq_not_yet", 32'(irq_take), 32'd0);
        rd_chk("mip_live", 12'h344, 32'h0000_0080);
        tick();
        check("irq_take_mti", 32'(irq_take), 32'd1);
        check("irq_cause_mti", irq_cause, 32'h8000_0007);
        trap_req = 1'b1; trap_cause = 32'h8000_0007; trap_epc = 32'h200; trap_tval = 32'd0;
        #1;
        check("trap_target_mti", trap_target, 32'h0000_011C);
        tick();
        trap_req = 1'b0;
        check("trap_mepc_out", mepc_out, 32'h200);
        rd_chk("trap_mepc", 12'h341, 32'h200);
        rd_chk("trap_mcause", 12'h342, 32'h8000_0007);
        rd_chk("trap_mstatus", 12'h300, 32'h0000_1880);
        tick();
        check("irq_drop", 32'(irq_take), 32'd0);
        check("irq_drop_cause", irq_cause, 32'd0);

        // MRET drops a simultaneous CSR write
        csr_addr = 12'h340; csr_op = 3'b001; csr_wdata = 32'hDEAD_BEEF; csr_we = 1'b1;
        mret_req = 1'b1;
        tick();
        mret_req = 1'b0; csr_we = 1'b0; csr_op = 3'b000;
        rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);
        rd_chk("mret_mscratch", 12'h340, 32'd0);
        check("mret_mepc_out", mepc_out, 32'h200);
        irq_mti = 1'b0;

        // Priority MEI over MSI; trap wins over CSR write to mepc
        csr_wr(12'h304, 3'b001, 32'h0000_0888);
        irq_mei = 1'b1; irq_msi = 1'b1;
        tick();
        check("irq_take_mei", 32'(irq_take), 32'd1);
        check("irq_cause_mei", irq_cause, 32'h8000_000B);
        csr_addr = 12'h341; csr_op = 3'b001; csr_wdata = 32'h1234_5678; csr_we = 1'b1;
        trap_req = 1'b1; trap_cause = 32'h8000_000B; trap_epc = 32'h303; trap_tval = 32'hABC;
        #1;
        check("trap_target_mei", trap_target, 32'h0000_012C);
        tick();
        trap_req = 1'b0; csr_we = 1'b0; csr_op = 3'b000;
        rd_chk("trap_over_wr_mepc", 12'h341, 32'h300);
        rd_chk("trap_mtval", 12'h343, 32'hABC);
        rd_chk("trap2_mstatus", 12'h300, 32'h0000_1880);
        trap_cause = 32'h0000_0002;
        #1;
        check("trap_target_exc", trap_target, 32'h0000_0100);
        csr_wr(12'h341, 3'b001, 32'h0000_0207);
        rd_chk("mepc_align", 12'h341, 32'h0000_0204);

        // Reset overrides strobes
        rst = 1'b1; trap_req = 1'b1; mret_req = 1'b1;
        tick();
        rst = 1'b0; trap_req = 1'b0; mret_req = 1'b0;
        irq_mei = 1'b0; irq_msi = 1'b0;
        check("rst2_irq_take", 32'(irq_take), 32'd0);
        rd_chk("rst2_mstatus", 12'h300, 32'h0000_1800);
        rd_chk("rst2_mepc", 12'h341, 32'd0);
        rd_chk("rst2_minstret", 12'hB02, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
